// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue
//
// Write-back stage in front of the register bank's single write port.
// Two producers (A = ALU pipe, B = load/multiply unit) offer results through
// valid/ready handshakes. A round-robin arbiter picks at most one per cycle.
// Accepted results go through a small FIFO into a registered write port.
// Writes to register 31 (XZR) are accepted and then dropped.
// Pending-destination flags let decode stall on read-after-write hazards.
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   a_valid/a_ready/a_reg/a_data   producer A handshake and payload
//   b_valid/b_ready/b_reg/b_data   producer B handshake and payload
//   wb_hold                   register bank cannot take a write this cycle
//   wb_write/wb_register/wb_data   registered write to the register bank
//   chk_reg1/chk_reg2         decode source operands to test
//   pend1/pend2               operand has a write queued or in flight
//   occupancy                 valid FIFO entries + wb_write
// ---------------------------------------------------------------------------
module writeback_queue #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        a_valid,
   output logic                        a_ready,
   input  logic [ADDR_W-1:0]           a_reg,
   input  logic [DATA_W-1:0]           a_data,
   input  logic                        b_valid,
   output logic                        b_ready,
   input  logic [ADDR_W-1:0]           b_reg,
   input  logic [DATA_W-1:0]           b_data,
   input  logic                        wb_hold,
   output logic                        wb_write,
   output logic [ADDR_W-1:0]           wb_register,
   output logic [DATA_W-1:0]           wb_data,
   input  logic [ADDR_W-1:0]           chk_reg1,
   input  logic [ADDR_W-1:0]           chk_reg2,
   output logic                        pend1,
   output logic                        pend2,
   output logic [$clog2(DEPTH+2)-1:0]  occupancy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int OCC_W = $clog2(DEPTH + 2);
   localparam logic [ADDR_W-1:0] XZR = '1;

   logic [ADDR_W-1:0] q_reg  [DEPTH];
   logic [DATA_W-1:0] q_data [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              last_b;

   logic              grant_a;
   logic              grant_b;
   logic              fifo_full;
   logic              fifo_empty;
   logic              xfer_a;
   logic              xfer_b;
   logic [ADDR_W-1:0] in_reg;
   logic [DATA_W-1:0] in_data;
   logic              in_keep;
   logic              advance;
   logic              pop;
   logic              bypass;
   logic              push;

   // Arbitration: a lone requester wins; on a tie the producer that was not
   // granted last time wins. Readiness also requires room in the FIFO, even
   // when the result could bypass, which keeps the full condition simple.
   always_comb begin
      fifo_full  = (count == CNT_W'(DEPTH));
      fifo_empty = (count == '0);
      grant_a    = a_valid & (~b_valid | last_b);
      grant_b    = b_valid & (~a_valid | ~last_b);
      a_ready    = grant_a & ~fifo_full;
      b_ready    = grant_b & ~fifo_full;
      xfer_a     = a_valid & a_ready;
      xfer_b     = b_valid & b_ready;
      in_reg     = xfer_b ? b_reg  : a_reg;
      in_data    = xfer_b ? b_data : a_data;
      // XZR writes finish the handshake but leave no trace downstream.
      in_keep    = (xfer_a | xfer_b) & (in_reg != XZR);
   end

   // The output register moves whenever it is empty or the bank consumes it.
   // An empty FIFO lets a fresh result skip straight to the output so that
   // single-cycle latency holds; otherwise the result is enqueued.
   always_comb begin
      advance = ~wb_write | ~wb_hold;
      pop     = advance & ~fifo_empty;
      bypass  = advance & fifo_empty & in_keep;
      push    = in_keep & ~bypass;
   end

   // Round-robin pointer moves only on an accepted transfer, so a stalled
   // (full) grant does not cost the other producer its turn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_b <= 1'b1;
      end else if (xfer_a) begin
         last_b <= 1'b0;
      end else if (xfer_b) begin
         last_b <= 1'b1;
      end
   end

   // FIFO pointers and count; pointers wrap naturally since DEPTH is 2^n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // FIFO storage needs no reset: entries are qualified by count.
   always_ff @(posedge clk) begin
      if (push) begin
         q_reg[wr_ptr]  <= in_reg;
         q_data[wr_ptr] <= in_data;
      end
   end

   // Registered write port to the register bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_write    <= 1'b0;
         wb_register <= '0;
         wb_data     <= '0;
      end else if (advance) begin
         if (pop) begin
            wb_write    <= 1'b1;
            wb_register <= q_reg[rd_ptr];
            wb_data     <= q_data[rd_ptr];
         end else if (bypass) begin
            wb_write    <= 1'b1;
            wb_register <= in_reg;
            wb_data     <= in_data;
         end else begin
            wb_write    <= 1'b0;
         end
      end
   end

   // Hazard check against every live FIFO slot and the in-flight write.
   // A slot is live when its distance from the read pointer is below count.
   always_comb begin
      logic [PTR_W-1:0] offset;
      logic             hit1;
      logic             hit2;
      offset = '0;
      hit1   = wb_write & (wb_register == chk_reg1);
      hit2   = wb_write & (wb_register == chk_reg2);
      for (int i = 0; i < DEPTH; i++) begin
         offset = PTR_W'(i) - rd_ptr;
         if (CNT_W'(offset) < count) begin
            if (q_reg[i] == chk_reg1) hit1 = 1'b1;
            if (q_reg[i] == chk_reg2) hit2 = 1'b1;
         end
      end
      pend1 = (chk_reg1 != XZR) & hit1;
      pend2 = (chk_reg2 != XZR) & hit2;
   end

   assign occupancy = OCC_W'(count) + OCC_W'(wb_write);

endmodule

// File: tb/tb_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_writeback_queue
//
// Directed bench for writeback_queue. Inputs change 1 time unit after the
// rising edge; combinational outputs are checked 1 unit later and registered
// outputs right after the next edge has settled.
// ---------------------------------------------------------------------------
module tb_writeback_queue;

   logic        clk;
   logic        rst_n;
   logic        a_valid;
   logic        a_ready;
   logic [4:0]  a_reg;
   logic [63:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_reg;
   logic [63:0] b_data;
   logic        wb_hold;
   logic        wb_write;
   logic [4:0]  wb_register;
   logic [63:0] wb_data;
   logic [4:0]  chk_reg1;
   logic [4:0]  chk_reg2;
   logic        pend1;
   logic        pend2;
   logic [2:0]  occupancy;

   int vectors;
   int miscompares;

   writeback_queue #(.DATA_W(64), .ADDR_W(5), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
      .wb_hold(wb_hold), .wb_write(wb_write), .wb_register(wb_register),
      .wb_data(wb_data), .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
      .pend1(pend1), .pend2(pend2), .occupancy(occupancy)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic av, input logic [4:0] ar,
                                input logic [63:0] ad, input logic bv,
                                input logic [4:0] br, input logic [63:0] bd,
                                input logic hold);
      a_valid = av; a_reg = ar; a_data = ad;
      b_valid = bv; b_reg = br; b_data = bd;
      wb_hold = hold;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
      tick();
   endtask

   // Linear sequence of directed steps with hand-computed expectations.
   initial begin
      vectors     = 0;
      miscompares = 0;
      chk_reg1    = 5'd0;
      chk_reg2    = 5'd0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      #3;

      // Reset state
      applyReset();
      checkOutput("rst_wb_write", 64'(wb_write), 64'd0);
      checkOutput("rst_wb_register", 64'(wb_register), 64'd0);
      checkOutput("rst_wb_data", wb_data, 64'd0);
      checkOutput("rst_occupancy", 64'(occupancy), 64'd0);

      // Single A write, bypass path, one-cycle latency
      applyStimulus(1, 5'd3, 64'h11, 0, 0, 0, 0);
      #1 checkOutput("t1_a_ready", 64'(a_ready), 64'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("t1_wb_write", 64'(wb_write), 64'd1);
      checkOutput("t1_wb_register", 64'(wb_register), 64'd3);
      checkOutput("t1_wb_data", wb_data, 64'h11);
      checkOutput("t1_occupancy", 64'(occupancy), 64'd1);
      tick();
      checkOutput("t1_wb_idle", 64'(wb_write), 64'd0);

      // Round-robin between A (r1..) and B (r5..), fresh pointer = last B
      applyReset();
      applyStimulus(1, 5'd1, 64'h101, 1, 5'd5, 64'h105, 0);
      #1 checkOutput("t2_c1_a_ready", 64'(a_ready), 64'd1);
      checkOutput("t2_c1_b_ready", 64'(b_ready), 64'd0);
      tick();
      checkOutput("t2_wb_r1", 64'(wb_register), 64'd1);
      checkOutput("t2_wb_d1", wb_data, 64'h101);
      applyStimulus(1, 5'd2, 64'h102, 1, 5'd5, 64'h105, 0);
      #1 checkOutput("t2_c2_a_ready", 64'(a_ready), 64'd0);
      checkOutput("t2_c2_b_ready", 64'(b_ready), 64'd1);
      tick();
      checkOutput("t2_wb_r5", 64'(wb_register), 64'd5);
      checkOutput("t2_wb_d5", wb_data, 64'h105);
      applyStimulus(1, 5'd2, 64'h102, 1, 5'd6, 64'h106, 0);
      #1 checkOutput("t2_c3_a_ready", 64'(a_ready), 64'd1);
      tick();
      checkOutput("t2_wb_r2", 64'(wb_register), 64'd2);
      applyStimulus(1, 5'd3, 64'h103, 1, 5'd6, 64'h106, 0);
      #1 checkOutput("t2_c4_b_ready", 64'(b_ready), 64'd1);
      checkOutput("t2_c4_a_ready", 64'(a_ready), 64'd0);
      tick();
      checkOutput("t2_wb_r6", 64'(wb_register), 64'd6);
      checkOutput("t2_wb_d6", wb_data, 64'h106);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("t2_wb_idle", 64'(wb_write), 64'd0);

      // Back-pressure: one write held in the output, four queued
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 5'(10 + i), 64'(16'hA00 + i), 0, 0, 0, 1);
         tick();
      end
      applyStimulus(1, 5'd15, 64'hA05, 0, 0, 0, 1);
      #1 checkOutput("t3_full_a_ready", 64'(a_ready), 64'd0);
      checkOutput("t3_occupancy", 64'(occupancy), 64'd5);
      checkOutput("t3_held_reg", 64'(wb_register), 64'd10);
      checkOutput("t3_held_write", 64'(wb_write), 64'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i < 5; i++) begin
         tick();
         checkOutput("t3_drain_reg", 64'(wb_register), 64'(10 + i));
         checkOutput("t3_drain_data", wb_data, 64'(16'hA00 + i));
         checkOutput("t3_drain_occ", 64'(occupancy), 64'(5 - i));
      end
      tick();
      checkOutput("t3_drained", 64'(wb_write), 64'd0);

      // XZR write is accepted and dropped
      chk_reg1 = 5'd31;
      applyStimulus(1, 5'd31, 64'hFF, 0, 0, 0, 0);
      #1 checkOutput("t4_a_ready", 64'(a_ready), 64'd1);
      checkOutput("t4_pend1_xzr", 64'(pend1), 64'd0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("t4_wb_write", 64'(wb_write), 64'd0);
      checkOutput("t4_occupancy", 64'(occupancy), 64'd0);
      #1 checkOutput("t4_pend1_after", 64'(pend1), 64'd0);

      // Pending flags: r20 in flight, r7 queued behind it
      chk_reg1 = 5'd7;
      chk_reg2 = 5'd20;
      applyStimulus(1, 5'd20, 64'h20, 0, 0, 0, 1);
      tick();
      applyStimulus(1, 5'd7, 64'h7, 0, 0, 0, 1);
      #1 checkOutput("t5_pend1_accepting", 64'(pend1), 64'd0);
      checkOutput("t5_pend2_inflight", 64'(pend2), 64'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      #1 checkOutput("t5_pend1_queued", 64'(pend1), 64'd1);
      checkOutput("t5_occ", 64'(occupancy), 64'd2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("t5_wb_r7", 64'(wb_register), 64'd7);
      checkOutput("t5_pend1_wb", 64'(pend1), 64'd1);
      checkOutput("t5_pend2_gone", 64'(pend2), 64'd0);
      tick();
      checkOutput("t5_pend1_gone", 64'(pend1), 64'd0);

      // Asynchronous reset mid-cycle discards queued writes
      chk_reg1 = 5'd2;
      for (int i = 1; i < 4; i++) begin
         applyStimulus(1, 5'(i), 64'(i), 0, 0, 0, 1);
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("t6_occ_before", 64'(occupancy), 64'd3);
      #1 checkOutput("t6_pend1_before", 64'(pend1), 64'd1);
      #1 rst_n = 1'b0;
      #1 checkOutput("t6_rst_wb_write", 64'(wb_write), 64'd0);
      checkOutput("t6_rst_occ", 64'(occupancy), 64'd0);
      checkOutput("t6_rst_pend1", 64'(pend1), 64'd0);
      #3 rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("t6_no_stale_1", 64'(wb_write), 64'd0);
      tick();
      checkOutput("t6_no_stale_2", 64'(wb_write), 64'd0);
      checkOutput("t6_occ_after", 64'(occupancy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard time limit so the run always ends on its own.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: observed running expected finished");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
